uart_tx_sched: RTL and testbench

Transmit scheduler for the SoC UART: buffers bytes that the CPU writes to the UART data register in a small FIFO, then feeds them one at a time to `corescore_emitter_uart` over its valid/ready handshake. It also supplies the UART status word for the IO read mux. The CPU no longer stalls on every byte, only when the FIFO is full. It sits in the SOC IO page, between the bus decode (`uart_valid`, status select) and the emitter.

---
 rtl/uart_sched_pkg.sv | 15 +
 rtl/uart_tx_sched_if.sv | 22 ++
 rtl/uart_tx_sched_byte_fifo.sv | 61 ++++++
 rtl/uart_tx_sched.sv | 97 +++++++++
 tb/tb_uart_tx_sched.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_sched_pkg.sv
// Shared constants for the UART transmit scheduler: status/control bit
// positions and scheduler state encoding.
package uart_sched_pkg;

  localparam int ST_IDLE = 8;
  localparam int ST_FULL = 9;
  localparam int ST_OVF  = 10;

  localparam int CTL_CLROVF = 0;
  localparam int CTL_FLUSH  = 1;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PRESENT = 1'b1;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Bus-side and emitter-side signals of the UART transmit scheduler.
// master = SOC/emitter side, slave = scheduler side.
interface uart_tx_sched_if;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        ctrl_wr;
  logic [1:0]  ctrl_data;
  logic [31:0] status;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output wr_en, wr_data, ctrl_wr, ctrl_data, tx_ready,
    input  status, tx_data, tx_valid
  );

  modport slave (
    input  wr_en, wr_data, ctrl_wr, ctrl_data, tx_ready,
    output status, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_tx_sched_byte_fifo.sv
// Circular byte buffer with occupancy counter; flush wins over push and pop.
module byte_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [7:0]    rd_data,
  output logic [LW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rp_reg;
  logic [AW-1:0] wp_reg;
  logic [LW-1:0] count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_reg == LW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign rd_data = mem[rp_reg];
  assign count   = count_reg;

  // Storage is deliberately left unreset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wp_reg] <= push_data;
    end
  end

  // Pointers are AW bits wide, so DEPTH being a power of two gives free wrap.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      rp_reg    <= '0;
      wp_reg    <= '0;
      count_reg <= '0;
    end else begin
      if (push_ok) begin
        wp_reg <= wp_reg + AW'(1);
      end
      if (pop_ok) begin
        rp_reg <= rp_reg + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + LW'(1);
        2'b01:   count_reg <= count_reg - LW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: FIFO-buffers CPU bytes, presents them one at a
// time to the emitter over valid/ready and builds the UART status word.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input logic             clk,
  input logic             resetn,
  uart_tx_sched_if.slave  bus
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [0:0]    state_reg;
  logic [7:0]    tx_data_reg;
  logic          tx_valid_reg;
  logic          ovf_reg;
  logic [7:0]    fifo_rd_data;
  logic [LW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          flush;
  logic          clr_ovf;
  logic          pop_go;
  logic [31:0]   status_w;

  assign flush   = bus.ctrl_wr && bus.ctrl_data[CTL_FLUSH];
  assign clr_ovf = bus.ctrl_wr && bus.ctrl_data[CTL_CLROVF];
  assign pop_go  = (state_reg == S_IDLE) && !fifo_empty && !flush;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (pop_go),
    .flush     (flush),
    .rd_data   (fifo_rd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A presented byte is held until accepted; flush does not cancel it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= S_IDLE;
      tx_data_reg  <= 8'h00;
      tx_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (pop_go) begin
            tx_data_reg  <= fifo_rd_data;
            tx_valid_reg <= 1'b1;
            state_reg    <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (bus.tx_ready) begin
            tx_valid_reg <= 1'b0;
            state_reg    <= S_IDLE;
          end
        end
        default: begin
          tx_valid_reg <= 1'b0;
          state_reg    <= S_IDLE;
        end
      endcase
    end
  end

  // A push discarded by a same-cycle flush is not counted as an overflow.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ovf_reg <= 1'b0;
    end else if (clr_ovf) begin
      ovf_reg <= 1'b0;
    end else if (bus.wr_en && fifo_full && !flush) begin
      ovf_reg <= 1'b1;
    end
  end

  always_comb begin
    status_w              = '0;
    status_w[LW-1:0]      = fifo_count;
    status_w[ST_IDLE]     = fifo_empty && !tx_valid_reg && bus.tx_ready;
    status_w[ST_FULL]     = fifo_full;
    status_w[ST_OVF]      = ovf_reg;
  end

  assign bus.status   = status_w;
  assign bus.tx_data  = tx_data_reg;
  assign bus.tx_valid = tx_valid_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a byte scoreboard on the emitter side.
module tb_uart_tx_sched;

  logic clk;
  logic resetn;

  uart_tx_sched_if ifc ();

  uart_tx_sched #(.DEPTH(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit accept);
    ifc.wr_en   = 1'b1;
    ifc.wr_data = b;
    if (accept) sb.push_back(b);
    tick();
    ifc.wr_en = 1'b0;
    $display("push 0x%02h accept=%0d status=0x%08h", b, accept, ifc.status);
  endtask

  task automatic ctrl(input logic [1:0] d);
    ifc.ctrl_wr   = 1'b1;
    ifc.ctrl_data = d;
    tick();
    ifc.ctrl_wr   = 1'b0;
    ifc.ctrl_data = 2'b00;
    $display("ctrl %b status=0x%08h", d, ifc.status);
  endtask

  task automatic wait_drain(input string tag);
    bit done = 0;
    for (int k = 0; k < 500; k++) begin
      if (sb.size() == 0 && ifc.status[8]) begin
        done = 1;
        break;
      end
      tick();
    end
    check(tag, 32'(done), 32'd1);
  endtask

  // Emitter-side monitor: pops the scoreboard on every accepted byte and
  // checks that a presented byte is held until it is accepted.
  logic       prev_rst = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (prev_rst && resetn && prev_valid && !prev_ready)
      check("hold", {23'd0, ifc.tx_valid, ifc.tx_data}, {23'd0, 1'b1, prev_data});
    if (resetn && ifc.tx_valid && ifc.tx_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_byte", {24'd0, ifc.tx_data}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        check("tx_data", {24'd0, ifc.tx_data}, {24'd0, e});
        $display("accept 0x%02h expected 0x%02h", ifc.tx_data, e);
      end
    end
    prev_rst   = resetn;
    prev_valid = ifc.tx_valid;
    prev_ready = ifc.tx_ready;
    prev_data  = ifc.tx_data;
  end

  initial begin
    int max_cnt;
    int k;
    resetn        = 1'b0;
    ifc.wr_en     = 1'b0;
    ifc.wr_data   = 8'h00;
    ifc.ctrl_wr   = 1'b0;
    ifc.ctrl_data = 2'b00;
    ifc.tx_ready  = 1'b1;
    tick();
    tick();
    resetn = 1'b1;
    check("reset_status", ifc.status, 32'h0000_0100);
    check("reset_valid", 32'(ifc.tx_valid), 32'd0);
    check("reset_data", 32'(ifc.tx_data), 32'd0);

    // Single byte: latency 2 cycles, accepted immediately.
    push(8'h41, 1);
    check("single_n1_valid", 32'(ifc.tx_valid), 32'd0);
    check("single_n1_status", ifc.status, 32'h0000_0001);
    tick();
    check("single_n2_valid", 32'(ifc.tx_valid), 32'd1);
    check("single_n2_data", 32'(ifc.tx_data), 32'h41);
    check("single_n2_status", ifc.status, 32'h0000_0000);
    tick();
    check("single_n3_status", ifc.status, 32'h0000_0100);

    // Fill with emitter stalled: 17 pushes, one is presented, 16 stored.
    ifc.tx_ready = 1'b0;
    for (int i = 0; i <= 16; i++) push(8'(i), 1);
    check("fill_status", ifc.status, 32'h0000_0210);
    check("fill_head", 32'(ifc.tx_data), 32'h00);
    ifc.tx_ready = 1'b1;
    wait_drain("fill_drain");
    check("fill_after", ifc.status, 32'h0000_0100);

    // Overflow: 18th push is dropped and flags ovf.
    ifc.tx_ready = 1'b0;
    for (int i = 0; i < 18; i++) push(8'(8'h20 + i), i < 17);
    check("ovf_status", ifc.status, 32'h0000_0610);
    ctrl(2'b01);
    check("ovf_clear", ifc.status, 32'h0000_0210);
    check("ovf_head", 32'(ifc.tx_data), 32'h20);
    ifc.tx_ready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_after", ifc.status, 32'h0000_0100);

    // Wrap-around with interleaved pushes and ready pulses.
    max_cnt = 0;
    k = 0;
    for (int i = 0; i < 120; i++) begin
      ifc.tx_ready = (i % 4 != 3);
      if (i % 3 == 0) begin
        ifc.wr_en   = 1'b1;
        ifc.wr_data = 8'(8'h60 + k);
        sb.push_back(8'(8'h60 + k));
        k++;
      end else begin
        ifc.wr_en = 1'b0;
      end
      tick();
      if (int'(ifc.status[4:0]) > max_cnt) max_cnt = int'(ifc.status[4:0]);
    end
    ifc.wr_en    = 1'b0;
    ifc.tx_ready = 1'b1;
    $display("wrap pushes=%0d max_count=%0d", k, max_cnt);
    check("wrap_max", 32'(max_cnt <= 16), 32'd1);
    wait_drain("wrap_drain");
    check("wrap_after", ifc.status, 32'h0000_0100);

    // Flush with concurrent push: presented byte survives, push discarded.
    ifc.tx_ready = 1'b0;
    push(8'hAA, 1);
    for (int i = 1; i <= 5; i++) push(8'(i), 1);
    check("flush_pre_status", ifc.status, 32'h0000_0005);
    check("flush_pre_data", 32'(ifc.tx_data), 32'hAA);
    ifc.wr_en   = 1'b1;
    ifc.wr_data = 8'h55;
    ctrl(2'b10);
    ifc.wr_en = 1'b0;
    sb.delete();
    sb.push_back(8'hAA);
    check("flush_status", ifc.status, 32'h0000_0000);
    check("flush_valid", 32'(ifc.tx_valid), 32'd1);
    check("flush_data", 32'(ifc.tx_data), 32'hAA);
    ifc.tx_ready = 1'b1;
    wait_drain("flush_drain");
    check("flush_after", ifc.status, 32'h0000_0100);

    // Reset while a byte is presented and three are queued.
    ifc.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'hB0 + i), 1);
    check("rst_pre_status", ifc.status, 32'h0000_0003);
    resetn       = 1'b0;
    ifc.tx_ready = 1'b1;
    tick();
    resetn = 1'b1;
    sb.delete();
    check("rst_valid", 32'(ifc.tx_valid), 32'd0);
    check("rst_data", 32'(ifc.tx_data), 32'd0);
    check("rst_status", ifc.status, 32'h0000_0100);
    tick();
    tick();
    check("rst_quiet_valid", 32'(ifc.tx_valid), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
